// File: rtl/sale_terminal_pkg.sv
// Shared sale-terminal types: direction codes, repeat-FSM states, grid defaults.
package sale_terminal_pkg;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef logic [1:0] rpt_state_t;

  localparam rpt_state_t RPT_IDLE   = 2'd0;
  localparam rpt_state_t RPT_DELAY  = 2'd1;
  localparam rpt_state_t RPT_REPEAT = 2'd2;

  localparam int unsigned DEF_COLS = 4;
  localparam int unsigned DEF_ROWS = 3;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 32'd1) ? 32'd1 : 32'($clog2(v));
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/grid_cursor_nav_if.sv
// Navigation bus between key decoding, cursor navigator and interactive controller.
interface grid_cursor_nav_if
  import sale_terminal_pkg::*;
#(
  parameter int unsigned ID_W  = 4,
  parameter int unsigned CNT_W = 5,
  parameter int unsigned ROW_W = 2,
  parameter int unsigned COL_W = 2
);
  logic             Enable;
  logic             BasketMode;
  logic             DirValid;
  dir_t             Dir_in;
  logic [CNT_W-1:0] BasketProductNum;
  logic [ID_W-1:0]  ProductID;
  logic [ROW_W-1:0] Row;
  logic [COL_W-1:0] Col;
  logic             Moved;
  logic             Blocked;

  modport master (
    output Enable, BasketMode, DirValid, Dir_in, BasketProductNum,
    input  ProductID, Row, Col, Moved, Blocked
  );

  modport slave (
    input  Enable, BasketMode, DirValid, Dir_in, BasketProductNum,
    output ProductID, Row, Col, Moved, Blocked
  );
endinterface

// File: rtl/key_repeat_timer.sv
// Held-key auto-repeat: IDLE/DELAY/REPEAT FSM producing a one-cycle move request.
module key_repeat_timer
  import sale_terminal_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic dir_valid,
  input  dir_t dir_in,
  output logic step_c,
  output dir_t dir_c
);
  localparam int unsigned TW = clog2_min1(max_u(HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic [TW-1:0] HOLD_LOAD   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REPEAT_LOAD = TW'(REPEAT_CYCLES - 1);

  rpt_state_t      state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  dir_t            dir_q, dir_d;

  // Every step acts on the key currently held; a repeat only fires when it equals dir_q.
  assign dir_c = dir_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    step_c  = 1'b0;
    if (!enable || !dir_valid) begin
      state_d = RPT_IDLE;
    end else begin
      case (state_q)
        RPT_DELAY, RPT_REPEAT: begin
          if (dir_in != dir_q) begin
            step_c  = 1'b1;
            dir_d   = dir_in;
            cnt_d   = HOLD_LOAD;
            state_d = RPT_DELAY;
          end else if (cnt_q == '0) begin
            step_c  = 1'b1;
            cnt_d   = REPEAT_LOAD;
            state_d = RPT_REPEAT;
          end else begin
            cnt_d = cnt_q - TW'(1);
          end
        end
        default: begin
          step_c  = 1'b1;
          dir_d   = dir_in;
          cnt_d   = HOLD_LOAD;
          state_d = RPT_DELAY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RPT_IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_LEFT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

endmodule

// File: rtl/grid_cursor_nav.sv
// Product-grid and basket cursor navigator with auto-repeat.
// Define GRID_NAV_WRAP_EN to wrap cursors at edges instead of clamping.
module grid_cursor_nav
  import sale_terminal_pkg::*;
#(
  parameter int unsigned COLS          = DEF_COLS,
  parameter int unsigned ROWS          = DEF_ROWS,
  parameter int unsigned BASKET_DEPTH  = 16,
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 12_500_000,
  parameter int unsigned ID_W          = clog2_min1(max_u(COLS * ROWS, BASKET_DEPTH)),
  parameter int unsigned CNT_W         = 32'($clog2(BASKET_DEPTH + 1))
) (
  input logic              CLOCK,
  input logic              RESET,
  grid_cursor_nav_if.slave bus
);
  localparam int unsigned N     = COLS * ROWS;
  localparam int unsigned ROW_W = clog2_min1(ROWS);
  localparam int unsigned COL_W = clog2_min1(COLS);
  localparam int unsigned W1    = ID_W + 1;
  localparam int unsigned XW    = max_u(ID_W, CNT_W) + 1;
  localparam logic [W1-1:0] N_W    = W1'(N);
  localparam logic [W1-1:0] COLS_W = W1'(COLS);
`ifdef GRID_NAV_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic step_c;
  dir_t dir_c;

  logic [ID_W-1:0]  grid_q, grid_d, basket_q, basket_d, pid_q, pid_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             moved_q, moved_d, blocked_q, blocked_d;

  logic [W1-1:0] g_ext, g_try;
  logic [XW-1:0] b_ext, b_try, cnt_ext;
  logic          g_edge, b_edge, b_move;

  key_repeat_timer #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_timer (
    .clk      (CLOCK),
    .rst      (RESET),
    .enable   (bus.Enable),
    .dir_valid(bus.DirValid),
    .dir_in   (bus.Dir_in),
    .step_c   (step_c),
    .dir_c    (dir_c)
  );

  // Candidate grid position; g_try holds the wrapped target when g_edge is set.
  always_comb begin
    g_ext  = {1'b0, grid_q};
    g_try  = g_ext;
    g_edge = 1'b0;
    case (dir_c)
      DIR_LEFT: begin
        g_edge = (g_ext == '0);
        g_try  = g_edge ? (N_W - W1'(1)) : (g_ext - W1'(1));
      end
      DIR_RIGHT: begin
        g_edge = ((g_ext + W1'(1)) >= N_W);
        g_try  = g_edge ? '0 : (g_ext + W1'(1));
      end
      DIR_UP: begin
        g_edge = (g_ext < COLS_W);
        g_try  = g_edge ? (g_ext + N_W - COLS_W) : (g_ext - COLS_W);
      end
      DIR_DOWN: begin
        g_edge = ((g_ext + COLS_W) >= N_W);
        g_try  = g_edge ? (g_ext + COLS_W - N_W) : (g_ext + COLS_W);
      end
      default: ;
    endcase
  end

  // Candidate basket position within 0..count-1.
  always_comb begin
    b_ext   = XW'(basket_q);
    cnt_ext = XW'(bus.BasketProductNum);
    b_try   = b_ext;
    b_edge  = 1'b0;
    b_move  = 1'b0;
    case (dir_c)
      DIR_UP: begin
        b_move = 1'b1;
        b_edge = (b_ext == '0);
        b_try  = b_edge ? (cnt_ext - XW'(1)) : (b_ext - XW'(1));
      end
      DIR_DOWN: begin
        b_move = 1'b1;
        b_edge = ((b_ext + XW'(1)) >= cnt_ext);
        b_try  = b_edge ? '0 : (b_ext + XW'(1));
      end
      default: ;
    endcase
  end

  // Cursor update; basket shrink overrides any same-cycle basket step.
  always_comb begin
    grid_d    = grid_q;
    basket_d  = basket_q;
    moved_d   = 1'b0;
    blocked_d = 1'b0;
    if (step_c && !bus.BasketMode) begin
      if (g_edge && !WRAP_EN) begin
        blocked_d = 1'b1;
      end else begin
        grid_d  = ID_W'(g_try);
        moved_d = (grid_d != grid_q);
      end
    end
    if (cnt_ext == '0) begin
      basket_d = '0;
      if (step_c && bus.BasketMode && b_move) blocked_d = 1'b1;
    end else if (b_ext >= cnt_ext) begin
      basket_d = ID_W'(cnt_ext - XW'(1));
    end else if (step_c && bus.BasketMode && b_move) begin
      if (b_edge && !WRAP_EN) begin
        blocked_d = 1'b1;
      end else begin
        basket_d = ID_W'(b_try);
        moved_d  = (basket_d != basket_q);
      end
    end
    pid_d = bus.BasketMode ? basket_d : grid_d;
    row_d = ROW_W'(32'(grid_d) / COLS);
    col_d = COL_W'(32'(grid_d) % COLS);
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      grid_q    <= '0;
      basket_q  <= '0;
      pid_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      moved_q   <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      grid_q    <= grid_d;
      basket_q  <= basket_d;
      pid_q     <= pid_d;
      row_q     <= row_d;
      col_q     <= col_d;
      moved_q   <= moved_d;
      blocked_q <= blocked_d;
    end
  end

  assign bus.ProductID = pid_q;
  assign bus.Row       = row_q;
  assign bus.Col       = col_q;
  assign bus.Moved     = moved_q;
  assign bus.Blocked   = blocked_q;

endmodule

// File: tb/tb_grid_cursor_nav.sv
// Scoreboard bench for grid_cursor_nav (4x3 grid, HOLD=4, REPEAT=2); honours GRID_NAV_WRAP_EN.
module tb_grid_cursor_nav;
  import sale_terminal_pkg::*;

  localparam int unsigned ID_W  = 4;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned ROW_W = 2;
  localparam int unsigned COL_W = 2;

  typedef struct packed {
    logic [3:0] pid;
    logic [1:0] row;
    logic [1:0] col;
    logic       moved;
    logic       blocked;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  grid_cursor_nav_if #(.ID_W(ID_W), .CNT_W(CNT_W), .ROW_W(ROW_W), .COL_W(COL_W)) bus ();

  grid_cursor_nav #(
    .COLS(4), .ROWS(3), .BASKET_DEPTH(16), .HOLD_CYCLES(4), .REPEAT_CYCLES(2),
    .ID_W(ID_W), .CNT_W(CNT_W)
  ) dut (
    .CLOCK(clk),
    .RESET(rst),
    .bus  (bus)
  );

  exp_t q[$];
  exp_t act_m, exp_m;
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t mk(input int pid, input int row, input int col, input bit blk);
    exp_t e;
    e.pid     = 4'(pid);
    e.row     = 2'(row);
    e.col     = 2'(col);
    e.moved   = !blk;
    e.blocked = blk;
    return e;
  endfunction

  // Monitor: every Moved/Blocked pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && (bus.Moved || bus.Blocked)) begin
      act_m = {bus.ProductID, bus.Row, bus.Col, bus.Moved, bus.Blocked};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse pid=%0d row=%0d col=%0d moved=%b blocked=%b",
                 act_m.pid, act_m.row, act_m.col, act_m.moved, act_m.blocked);
      end else begin
        exp_m = q.pop_front();
        if (act_m !== exp_m) begin
          errors++;
          $display("FAIL pulse got pid=%0d row=%0d col=%0d mv=%b blk=%b want pid=%0d row=%0d col=%0d mv=%b blk=%b",
                   act_m.pid, act_m.row, act_m.col, act_m.moved, act_m.blocked,
                   exp_m.pid, exp_m.row, exp_m.col, exp_m.moved, exp_m.blocked);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input dir_t d, input int n);
    bus.Dir_in   = d;
    bus.DirValid = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    bus.DirValid = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.DirValid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pid"}, int'(bus.ProductID), 0);
    chk({tag, "_row"}, int'(bus.Row), 0);
    chk({tag, "_col"}, int'(bus.Col), 0);
    chk({tag, "_moved"}, int'(bus.Moved), 0);
    chk({tag, "_blocked"}, int'(bus.Blocked), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus.Enable           = 1'b1;
    bus.BasketMode       = 1'b0;
    bus.DirValid         = 1'b0;
    bus.Dir_in           = DIR_LEFT;
    bus.BasketProductNum = '0;
    tick();
    tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // Left from 0, then down to the bottom edge
`ifdef GRID_NAV_WRAP_EN
    q.push_back(mk(11, 2, 3, 0));
`else
    q.push_back(mk(0, 0, 0, 1));
`endif
    press(DIR_LEFT, 1);
    do_reset();
    q.push_back(mk(4, 1, 0, 0));
    q.push_back(mk(8, 2, 0, 0));
`ifdef GRID_NAV_WRAP_EN
    q.push_back(mk(0, 0, 0, 0));
`else
    q.push_back(mk(8, 2, 0, 1));
`endif
    press(DIR_DOWN, 1);
    press(DIR_DOWN, 1);
    press(DIR_DOWN, 1);

    // Auto-repeat: 12 held edges give steps at 0, 4, 6, 8, 10
    do_reset();
    q.push_back(mk(1, 0, 1, 0));
    q.push_back(mk(2, 0, 2, 0));
    q.push_back(mk(3, 0, 3, 0));
    q.push_back(mk(4, 1, 0, 0));
    q.push_back(mk(5, 1, 1, 0));
    press(DIR_RIGHT, 12);
    chk("repeat_grid", int'(bus.ProductID), 5);
    chk("repeat_drained", q.size(), 0);

    // Right/up edges from the last cell
    do_reset();
    q.push_back(mk(4, 1, 0, 0));
    q.push_back(mk(8, 2, 0, 0));
    q.push_back(mk(9, 2, 1, 0));
    q.push_back(mk(10, 2, 2, 0));
    q.push_back(mk(11, 2, 3, 0));
    press(DIR_DOWN, 1);
    press(DIR_DOWN, 1);
    for (int i = 0; i < 3; i++) press(DIR_RIGHT, 1);
`ifdef GRID_NAV_WRAP_EN
    q.push_back(mk(0, 0, 0, 0));
    q.push_back(mk(1, 0, 1, 0));
    q.push_back(mk(9, 2, 1, 0));
    press(DIR_RIGHT, 1);
    press(DIR_RIGHT, 1);
    press(DIR_UP, 1);
`else
    q.push_back(mk(11, 2, 3, 1));
    q.push_back(mk(7, 1, 3, 0));
    q.push_back(mk(3, 0, 3, 0));
    q.push_back(mk(3, 0, 3, 1));
    press(DIR_RIGHT, 1);
    press(DIR_UP, 1);
    press(DIR_UP, 1);
    press(DIR_UP, 1);
`endif

    // Mode retention: grid at 7, basket moves, switch back
    do_reset();
    q.push_back(mk(4, 1, 0, 0));
    q.push_back(mk(5, 1, 1, 0));
    q.push_back(mk(6, 1, 2, 0));
    q.push_back(mk(7, 1, 3, 0));
    press(DIR_DOWN, 1);
    for (int i = 0; i < 3; i++) press(DIR_RIGHT, 1);
    bus.BasketProductNum = 5'd5;
    bus.BasketMode       = 1'b1;
    tick();
    chk("mode_to_basket_pid", int'(bus.ProductID), 0);
    chk("mode_to_basket_moved", int'(bus.Moved), 0);
    q.push_back(mk(1, 1, 3, 0));
    q.push_back(mk(2, 1, 3, 0));
    press(DIR_DOWN, 1);
    press(DIR_DOWN, 1);
    bus.BasketMode = 1'b0;
    tick();
    chk("mode_to_grid_pid", int'(bus.ProductID), 7);
    chk("mode_to_grid_moved", int'(bus.Moved), 0);

    // Basket top edge with count 3; left is ignored
    bus.BasketMode       = 1'b1;
    bus.BasketProductNum = 5'd3;
    tick();
    q.push_back(mk(1, 1, 3, 0));
    q.push_back(mk(0, 1, 3, 0));
`ifdef GRID_NAV_WRAP_EN
    q.push_back(mk(2, 1, 3, 0));
`else
    q.push_back(mk(0, 1, 3, 1));
`endif
    press(DIR_UP, 1);
    press(DIR_UP, 1);
    press(DIR_UP, 1);
    press(DIR_LEFT, 1);

    // Basket shrink and empty basket
    bus.BasketProductNum = 5'd5;
    do_reset();
    q.push_back(mk(1, 0, 0, 0));
    q.push_back(mk(2, 0, 0, 0));
    q.push_back(mk(3, 0, 0, 0));
    q.push_back(mk(4, 0, 0, 0));
    for (int i = 0; i < 4; i++) press(DIR_DOWN, 1);
    bus.BasketProductNum = 5'd2;
    tick();
    chk("shrink_pid", int'(bus.ProductID), 1);
    bus.BasketProductNum = 5'd0;
    tick();
    chk("empty_pid", int'(bus.ProductID), 0);
    q.push_back(mk(0, 0, 0, 1));
    press(DIR_DOWN, 1);

    // Disabled navigation holds the cursor
    bus.BasketMode = 1'b0;
    bus.Enable     = 1'b0;
    press(DIR_RIGHT, 3);
    chk("disabled_pid", int'(bus.ProductID), 0);
    bus.Enable = 1'b1;
    tick();

    // Reset while repeating, then still-held key counts as a new press
    q.push_back(mk(1, 0, 1, 0));
    q.push_back(mk(2, 0, 2, 0));
    q.push_back(mk(3, 0, 3, 0));
    bus.Dir_in   = DIR_RIGHT;
    bus.DirValid = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    tick();
    tick();
    rst = 1'b0;
    q.push_back(mk(1, 0, 1, 0));
    q.push_back(mk(2, 0, 2, 0));
    repeat (6) @(posedge clk);
    #1;
    bus.DirValid = 1'b0;
    tick();
    chk("post_rst_pid", int'(bus.ProductID), 2);

    tick();
    tick();
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
